// File: rtl/adc_axis_frame_packer_if.sv
// AXI4-Stream beat channel carrying packed ADC sample pairs plus the frame-end flag.
interface adc_axis_frame_packer_if;
    logic        TVALID;
    logic [31:0] TDATA;
    logic [3:0]  TKEEP;
    logic        TLAST;
    logic        TREADY;

    modport master (output TVALID, output TDATA, output TKEEP, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TKEEP, input TLAST, output TREADY);
endinterface

// File: rtl/adc_axis_frame_packer.sv
// Packs 16-bit ADC samples two per 32-bit beat into fixed-length TLAST-terminated frames,
// buffered in a first-word-fall-through FIFO; frames that cannot fit are dropped whole.
module adc_axis_frame_packer #(
    parameter int FRAME_WORDS = 512,
    parameter int FIFO_DEPTH  = 1024
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic                           ENABLE,
    input  logic                           S_VALID,
    input  logic [15:0]                    S_DATA,
    adc_axis_frame_packer_if.master        m_axis,
    output logic                           BUSY,
    output logic [15:0]                    DROP_CNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(FRAME_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // A frame is admitted only when a whole frame of beats still fits.
    localparam logic [AW:0]   ADMIT_MAX = (AW + 1)'(FIFO_DEPTH - FRAME_WORDS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_WORDS - 1);

    logic [1:0]    state;
    logic          phase;
    logic [BW-1:0] beat_cnt;
    logic [15:0]   high_half;

    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   occupancy;
    logic [32:0]   head;
    logic          fifo_empty;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          frame_start;

    assign occupancy   = wr_ptr - rd_ptr;
    assign fifo_empty  = (occupancy == '0);
    assign frame_start = (state == ST_IDLE) && ENABLE && S_VALID;
    assign fifo_wr     = (state == ST_FILL) && S_VALID && phase;
    assign fifo_rd     = m_axis.TVALID && m_axis.TREADY;
    assign head        = mem[rd_ptr[AW-1:0]];

    // Head entry is gated while empty so TDATA/TLAST read as zero after reset.
    assign m_axis.TVALID = !fifo_empty;
    assign m_axis.TDATA  = fifo_empty ? 32'h0 : head[31:0];
    assign m_axis.TLAST  = !fifo_empty && head[32];
    assign m_axis.TKEEP  = 4'hF;

    assign BUSY = (state != ST_IDLE);

    // DROP reuses the phase/beat counters so it swallows exactly one frame of samples.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= ST_IDLE;
            phase     <= 1'b0;
            beat_cnt  <= '0;
            high_half <= 16'h0;
            DROP_CNT  <= 16'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        phase     <= 1'b1;
                        beat_cnt  <= '0;
                        high_half <= S_DATA;
                        if (occupancy <= ADMIT_MAX) begin
                            state <= ST_FILL;
                        end else begin
                            state <= ST_DROP;
                            if (DROP_CNT != 16'hFFFF) begin
                                DROP_CNT <= DROP_CNT + 16'h1;
                            end
                        end
                    end
                end
                ST_FILL, ST_DROP: begin
                    if (S_VALID) begin
                        if (!phase) begin
                            high_half <= S_DATA;
                            phase     <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (beat_cnt == LAST_BEAT) begin
                                beat_cnt <= '0;
                                state    <= ST_IDLE;
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (fifo_wr) begin
            mem[wr_ptr[AW-1:0]] <= {(beat_cnt == LAST_BEAT), high_half, S_DATA};
        end
    end

endmodule
